// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO pair.
// Magnitudes are iterated unsigned; sign correction happens in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    input  logic               flush,
    output logic               busy,
    output logic               multWe,
    output logic [2*WIDTH-1:0] busmult,
    output logic               divZero
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_sign_a, r_sign_b, r_dz;
    logic [WIDTH-1:0]   r_opnd, r_raw_a;
    logic [2*WIDTH-1:0] r_acc, r_busmult;

    logic               w_signed, w_neg_a, w_neg_b;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem;
    logic [WIDTH:0]     w_sum, w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod, w_fix;

    assign w_signed = ~op[0];
    assign w_neg_a  = w_signed & srcA[WIDTH-1];
    assign w_neg_b  = w_signed & srcB[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -srcA : srcA;
    assign w_abs_b  = w_neg_b ? -srcB : srcB;

    // Shift-add: the carry out of the upper-half add becomes the new MSB.
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_nxt = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs one extra bit before the trial subtract.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    assign w_div_nxt = w_diff[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quot = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix  = !r_div ? w_prod : r_dz ? {r_raw_a, {WIDTH{1'b1}}} : {w_rem, w_quot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? CALC : IDLE;
            CALC:    w_next = (r_cnt == CW'(ITER - 1)) ? FIX : CALC;
            FIX:     w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_dz      <= 1'b0;
            r_opnd    <= '0;
            r_raw_a   <= '0;
            r_acc     <= '0;
            r_busmult <= '0;
        end else begin
            if (r_state == IDLE && w_next == CALC) begin
                r_cnt    <= '0;
                r_div    <= op[1];
                r_sign_a <= w_neg_a;
                r_sign_b <= w_neg_b;
                r_dz     <= op[1] && srcB == '0;
                r_raw_a  <= srcA;
                r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                r_acc    <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
            end
            if (r_state == CALC) begin
                r_acc <= r_div ? w_div_nxt : w_mul_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == FIX && w_next == DONE) r_busmult <= w_fix;
        end
    end

    assign busy    = r_state != IDLE;
    assign multWe  = r_state == DONE;
    assign divZero = multWe & r_dz;
    assign busmult = r_busmult;
endmodule
